// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the CPU EX/MEM stage and a
// DMA/host requester. Grant is combinational. An aging counter keeps the DMA
// from starving, locked DMA bursts are supported, and read data is routed back
// to whichever requester issued the read.
module dmem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned          CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]     STARVE_LIM = CNT_W'(STARVE_MAX);

    localparam logic [1:0] CPU_PRI  = 2'd0;
    localparam logic [1:0] DMA_PRI  = 2'd1;
    localparam logic [1:0] DMA_LOCK = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0] rd_own_q, rd_own_d;   // 1 = DMA issued the read
    logic              cpu_sel, dma_sel;
    logic              cpu_xfer, dma_xfer, rd_push;

    // Requester selection from the current priority state; nothing selected in reset
    always_comb begin
        cpu_sel = 1'b0;
        dma_sel = 1'b0;
        case (state_q)
            DMA_LOCK: dma_sel = dma_req;
            DMA_PRI: begin
                dma_sel = dma_req;
                cpu_sel = cpu_req & ~dma_req;
            end
            default: begin
                cpu_sel = cpu_req;
                dma_sel = dma_req & ~cpu_req;
            end
        endcase
        if (rst) begin
            cpu_sel = 1'b0;
            dma_sel = 1'b0;
        end
    end

    assign cpu_xfer  = cpu_sel & mem_ready;
    assign dma_xfer  = dma_sel & mem_ready;
    assign rd_push   = (cpu_xfer & ~cpu_wr) | (dma_xfer & ~dma_wr);

    assign mem_req   = cpu_sel | dma_sel;
    assign mem_wr    = dma_sel ? dma_wr    : cpu_wr;
    assign mem_addr  = dma_sel ? dma_addr  : cpu_addr;
    assign mem_wdata = dma_sel ? dma_wdata : cpu_wdata;

    assign cpu_stall = cpu_req & ~cpu_xfer & ~rst;
    assign dma_gnt   = dma_xfer;

    assign cpu_rvalid = rd_vld_q[RD_LAT-1] & ~rd_own_q[RD_LAT-1];
    assign dma_rvalid = rd_vld_q[RD_LAT-1] &  rd_own_q[RD_LAT-1];
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = mem_rdata;

    // Aging counter and priority-state transitions
    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (dma_xfer) begin
            starve_d = '0;
        end else if (dma_req && cpu_xfer && starve_q != STARVE_LIM) begin
            starve_d = starve_q + CNT_W'(1);
        end
        case (state_q)
            CPU_PRI: begin
                if (dma_xfer) begin
                    state_d = dma_lock ? DMA_LOCK : CPU_PRI;
                end else if (starve_d == STARVE_LIM) begin
                    state_d = DMA_PRI;
                end
            end
            DMA_PRI: begin
                if (dma_xfer) begin
                    state_d = dma_lock ? DMA_LOCK : CPU_PRI;
                end
            end
            DMA_LOCK: begin
                if (dma_xfer) begin
                    state_d = dma_lock ? DMA_LOCK : CPU_PRI;
                end else if (!dma_req) begin
                    state_d = CPU_PRI;
                end
            end
            default: state_d = CPU_PRI;
        endcase
    end

    // Read-owner shift register: the width cast drops the oldest entry
    always_comb begin
        rd_vld_d = RD_LAT'({rd_vld_q, rd_push});
        rd_own_d = RD_LAT'({rd_own_q, dma_xfer});
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CPU_PRI;
            starve_q <= '0;
            rd_vld_q <= '0;
            rd_own_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rd_vld_q <= rd_vld_d;
            rd_own_q <= rd_own_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level reference model of the arbiter.
module tb_dmem_arbiter;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;
    localparam int SMAX   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_wr, cpu_stall, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          dma_req, dma_wr, dma_lock, dma_gnt, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata, dma_rdata;
    logic          mem_req, mem_wr, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: who holds priority, how long the DMA has waited, and
    // the list of outstanding reads with the cycle each one is due back.
    typedef struct { int due; bit dma; } rd_t;
    rd_t pend[$];
    bit  m_locked, m_dma_pri;
    int  m_wait;
    int  cyc;

    // Last observed outputs, for directed assertions
    bit o_gnt, o_stall, o_cv, o_dv;

    task automatic model_reset();
        m_locked  = 0;
        m_dma_pri = 0;
        m_wait    = 0;
        pend.delete();
    endtask

    // One clock cycle: compare outputs mid-cycle, advance the model, drive next inputs
    task automatic step();
        bit cs, ds, cx, dx, ev_c, ev_d;
        @(negedge clk);
        o_gnt = dma_gnt; o_stall = cpu_stall; o_cv = cpu_rvalid; o_dv = dma_rvalid;
        if (rst) begin
            check("rst_mem_req", mem_req, 0);
            check("rst_dma_gnt", dma_gnt, 0);
            check("rst_cpu_stall", cpu_stall, 0);
            check("rst_rvalid", {cpu_rvalid, dma_rvalid}, 0);
            model_reset();
        end else begin
            if (m_locked) begin
                cs = 0; ds = dma_req;
            end else if (m_dma_pri) begin
                ds = dma_req; cs = cpu_req && !dma_req;
            end else begin
                cs = cpu_req; ds = dma_req && !cpu_req;
            end
            cx = cs && mem_ready;
            dx = ds && mem_ready;
            check("mem_req", mem_req, cs || ds);
            check("mem_addr", mem_addr, ds ? dma_addr : cpu_addr);
            check("mem_wdata", mem_wdata, ds ? dma_wdata : cpu_wdata);
            if (cs || ds) check("mem_wr", mem_wr, ds ? dma_wr : cpu_wr);
            check("cpu_stall", cpu_stall, cpu_req && !cx);
            check("dma_gnt", dma_gnt, dx);
            ev_c = 0; ev_d = 0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                if (pend[0].dma) ev_d = 1; else ev_c = 1;
                void'(pend.pop_front());
            end
            check("cpu_rvalid", cpu_rvalid, ev_c);
            check("dma_rvalid", dma_rvalid, ev_d);
            if (ev_c) check("cpu_rdata", cpu_rdata, mem_rdata);
            if (ev_d) check("dma_rdata", dma_rdata, mem_rdata);
            // advance model
            if (cx && !cpu_wr) pend.push_back('{due: cyc + RD_LAT, dma: 1'b0});
            if (dx && !dma_wr) pend.push_back('{due: cyc + RD_LAT, dma: 1'b1});
            if (dx) begin
                m_wait    = 0;
                m_locked  = dma_lock;
                m_dma_pri = 0;
            end else begin
                if (dma_req && cx && m_wait < SMAX) m_wait++;
                if (m_locked && !dma_req) m_locked = 0;
                if (!m_locked && !m_dma_pri && m_wait == SMAX) m_dma_pri = 1;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
        mem_rdata = $urandom();
    endtask

    int first_gnt, gnt_cnt, stall_cnt, t_dv, t_cv;
    bit both, saw_cv;

    initial begin
        rst = 1; cyc = 0;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_wr = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
        mem_ready = 1; mem_rdata = '0;
        model_reset();
        @(posedge clk); #1;
        step(); step();
        rst = 0;
        step();
        check("reset_idle_mem_req", mem_req, 0);

        // 1: lone CPU read
        cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h100;
        step();
        check("t1_addr", mem_addr, 32'h100);
        check("t1_stall", o_stall, 0);
        cpu_req = 0;
        step();
        step();
        check("t1_rvalid", {o_cv, o_dv}, 2'b10);

        // 2: continuous contention, aging hands the port to the DMA on cycle 9
        cpu_req = 1; cpu_wr = 1; dma_req = 1; dma_wr = 1; dma_lock = 0;
        first_gnt = 0; gnt_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            cpu_wdata = $urandom(); dma_wdata = $urandom(); dma_addr = $urandom();
            step();
            if (o_gnt) begin
                gnt_cnt++;
                if (first_gnt == 0) first_gnt = i;
            end
            if (i == 9) check("t2_c9_stall", o_stall, 1);
            if (i == 10) check("t2_c10_stall", o_stall, 0);
        end
        check("t2_first_gnt", first_gnt, 9);
        check("t2_gnt_cnt", gnt_cnt, 1);

        // 3: age the DMA in, then a locked burst of 4 writes
        dma_lock = 1;
        for (int i = 0; i < 8; i++) step();
        gnt_cnt = 0; stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            dma_lock = (i < 3);
            dma_addr = 32'h2000 + 4 * i;
            step();
            gnt_cnt += o_gnt;
            stall_cnt += o_stall;
        end
        check("t3_burst_gnt", gnt_cnt, 4);
        check("t3_burst_stall", stall_cnt, 4);
        step();
        check("t3_cpu_after", {o_stall, o_gnt}, 2'b00);
        dma_req = 0; dma_lock = 0;

        // 4: memory not ready for 3 cycles
        cpu_req = 1; cpu_wr = 0; mem_ready = 0; stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            stall_cnt += o_stall;
        end
        check("t4_stalls", stall_cnt, 3);
        mem_ready = 1;
        step();
        check("t4_accept", o_stall, 0);
        cpu_req = 0;
        step(); step();

        // 5: DMA read then CPU read back to back
        dma_req = 1; dma_wr = 0;
        step();
        dma_req = 0; cpu_req = 1; cpu_wr = 0;
        step();
        cpu_req = 0;
        t_dv = 0; t_cv = 0; both = 0;
        for (int i = 2; i <= 4; i++) begin
            step();
            if (o_dv && t_dv == 0) t_dv = i;
            if (o_cv && t_cv == 0) t_cv = i;
            if (o_dv && o_cv) both = 1;
        end
        check("t5_dma_rvalid_t", t_dv, 2);
        check("t5_cpu_rvalid_t", t_cv, 3);
        check("t5_overlap", both, 0);

        // 6: reset while a CPU read is in flight
        cpu_req = 1; cpu_wr = 0;
        step();
        cpu_req = 0; rst = 1; saw_cv = 0;
        step();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            saw_cv |= o_cv;
        end
        check("t6_no_rvalid", saw_cv, 0);
        cpu_req = 1; cpu_wr = 1; dma_req = 1; dma_wr = 1;
        step();
        check("t6_cpu_pri", {o_stall, o_gnt}, 2'b00);
        cpu_req = 0; dma_req = 0;
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cpu_req   = ($urandom_range(0, 3) != 0);
            cpu_wr    = $urandom_range(0, 1);
            cpu_addr  = $urandom();
            cpu_wdata = $urandom();
            dma_req   = ($urandom_range(0, 2) != 0);
            dma_wr    = $urandom_range(0, 1);
            dma_lock  = ($urandom_range(0, 3) == 0);
            dma_addr  = $urandom();
            dma_wdata = $urandom();
            mem_ready = ($urandom_range(0, 4) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
